// File: rtl/ram_lane_responder.sv
`timescale 1ns/1ps
// ============================================================================
// ram_lane_responder
//
// Purpose:
//   This is a synchronous byte-lane RAM slave at the far end of the memory
//   controller RAM bus. Reads and writes are decoded per lane into an internal
//   array of 32-bit words. Each access waits WAIT_STATES extra cycles and then
//   finishes with a single-cycle ram_ready pulse.
//
//   On a read, the word is held in a read register. That register drives the
//   enabled lanes while the access stays in DONE or HOLD. The master keeps the
//   request {addr, rw, enables} stable until it has seen ram_ready. After that
//   it may change the request or drop every enable.
//
// Optional feature (macro RAM_BOUNDS_CHECK_EN):
//   When the macro is defined, the ram_err port exists. Two cases are faults:
//     - a request with address bits above the array, or
//     - a request with a non-word-aligned address.
//   A faulting access still completes, but it writes nothing and reads 0.
//   ram_err pulses in the same cycle as ram_ready.
//   When the macro is undefined, the high address bits and ram_addr[1:0] are
//   ignored, so addresses alias.
//
// Parameters:
//   ADDR_W       word-address width; the array depth is 2**ADDR_W words
//   WAIT_STATES  extra cycles between request capture and completion (0..15)
//   CNT_W        width of the wait counter; it must be able to hold WAIT_STATES
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous reset, active low
//   ram_addr[31:0]      byte address; the word index is ram_addr[ADDR_W+1:2]
//   ram_rw              1 = write, 0 = read
//   ram_en1h/1l/2h/2l   lane enables for bits 31:24 / 23:16 / 15:8 / 7:0
//   ram_data1h..2l      bidirectional 8-bit lane data
//   ram_ready           one-cycle completion pulse
//   ram_err             fault pulse (present only with RAM_BOUNDS_CHECK_EN)
// ============================================================================
module ram_lane_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ram_addr,
   input  logic        ram_rw,
   input  logic        ram_en1h,
   input  logic        ram_en1l,
   input  logic        ram_en2h,
   input  logic        ram_en2l,
   inout  logic [7:0]  ram_data1h,
   inout  logic [7:0]  ram_data1l,
   inout  logic [7:0]  ram_data2h,
   inout  logic [7:0]  ram_data2l,
   output logic        ram_ready
`ifdef RAM_BOUNDS_CHECK_EN
   ,
   output logic        ram_err
`endif
);

   localparam int               DEPTH     = 2**ADDR_W;
   localparam int               KEY_W     = 37;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [KEY_W-1:0]   r_key;
   logic [31:0]        r_rd;
   logic [31:0]        r_mem [0:DEPTH-1];

   logic [3:0]         w_en;
   logic [31:0]        w_bus_in;
   logic [KEY_W-1:0]   w_key;
   logic [ADDR_W-1:0]  w_idx;
   logic               w_req;
   logic               w_fault;
   logic               w_start;
   logic               w_latch;
   logic               w_enter_done;
   logic               w_we;
   logic               w_drive;
   logic [3:0]         w_lane_oe;

   // Bit 3 is lane 1h (31:24) and bit 0 is lane 2l (7:0).
   // This matches the byte order of the data word.
   assign w_en     = {ram_en1h, ram_en1l, ram_en2h, ram_en2l};
   assign w_bus_in = {ram_data1h, ram_data1l, ram_data2h, ram_data2l};
   assign w_req    = |w_en;
   assign w_key    = {ram_addr, ram_rw, w_en};
   assign w_idx    = ram_addr[ADDR_W+1:2];

`ifdef RAM_BOUNDS_CHECK_EN
   assign w_fault = (ram_addr[31:ADDR_W+2] != '0) || (ram_addr[1:0] != 2'b00);
`else
   assign w_fault = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // A fresh request from IDLE, a changed key in WAIT, and a changed key in
   // HOLD all take the same start path. Each of them relatches the key and
   // reloads the counter.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_start      = 1'b0;
      w_latch      = 1'b0;
      w_enter_done = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_req) w_start = 1'b1;
         end
         S_WAIT: begin
            if (!w_req) begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else if (w_key != r_key) begin
               w_start = 1'b1;
            end else if (r_cnt <= CNT_W'(1)) begin
               w_state_next = S_DONE;
               w_enter_done = 1'b1;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         S_DONE: begin
            w_state_next = S_HOLD;
         end
         S_HOLD: begin
            if (!w_req)                 w_state_next = S_IDLE;
            else if (w_key != r_key)    w_start      = 1'b1;
         end
         default: w_state_next = S_IDLE;
      endcase

      if (w_start) begin
         w_latch = 1'b1;
         if (WAIT_STATES == 0) begin
            w_state_next = S_DONE;
            w_enter_done = 1'b1;
            w_cnt_next   = '0;
         end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = WAIT_LOAD;
         end
      end
   end

   // The write is gated by rst_n. A clock edge that arrives while reset is
   // asserted must never store a word.
   assign w_we = w_enter_done & ram_rw & ~w_fault & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_key   <= '0;
         r_rd    <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_latch) r_key <= w_key;
         // The key cannot differ from the latched key when DONE is entered.
         // The live inputs are therefore the request being completed.
         if (w_enter_done && !ram_rw) r_rd <= w_fault ? 32'h0 : r_mem[w_idx];
      end
   end

   // The array is not reset, so its contents survive rst_n.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_we && w_en[i]) r_mem[w_idx][i*8 +: 8] <= w_bus_in[i*8 +: 8];
      end
   end

`ifdef RAM_BOUNDS_CHECK_EN
   logic r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_err <= 1'b0;
      else if (w_enter_done) r_err <= w_fault;
   end
   assign ram_err = (r_state == S_DONE) && r_err;
`endif

   assign ram_ready = (r_state == S_DONE);

   // A lane is driven only when all of these hold:
   //   - the state is DONE or HOLD,
   //   - the latched op is a read (key bit 4 is the latched rw),
   //   - the current ram_rw is 0,
   //   - the lane is currently enabled.
   // The ram_rw term stops a bus fight with a master that has already turned
   // around to write.
   assign w_drive = ((r_state == S_DONE) || (r_state == S_HOLD)) && !r_key[4] && !ram_rw;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane_oe
         assign w_lane_oe[gi] = w_drive & w_en[gi];
      end
   endgenerate

   assign ram_data1h = w_lane_oe[3] ? r_rd[31:24] : 8'bz;
   assign ram_data1l = w_lane_oe[2] ? r_rd[23:16] : 8'bz;
   assign ram_data2h = w_lane_oe[1] ? r_rd[15:8]  : 8'bz;
   assign ram_data2l = w_lane_oe[0] ? r_rd[7:0]   : 8'bz;

endmodule

// File: tb/tb_ram_lane_responder.sv
`timescale 1ns/1ps
// Testbench for ram_lane_responder.
// - Two responders share one stimulus bus:
//     u_dut_a has WAIT_STATES=1,
//     u_dut_b has WAIT_STATES=0.
//   Each responder has its own data lanes.
// - When a request is driven, the expected completions are pushed onto a
//   queue for each responder.
// - A monitor on the falling edge pops an entry on every ram_ready pulse. It
//   then checks the completion cycle and the lane data.
module tb_ram_lane_responder;
   localparam int ADDR_W = 10;
   localparam int WS_A   = 1;
   localparam int WS_B   = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] s_addr = '0;
   logic        s_rw   = 1'b0;
   logic [3:0]  s_en   = '0;
   logic [31:0] s_wd   = '0;
   logic        s_drv  = 1'b0;

   wire [7:0] a_1h, a_1l, a_2h, a_2l;
   wire [7:0] b_1h, b_1l, b_2h, b_2l;
   wire       rdy_a, rdy_b;
`ifdef RAM_BOUNDS_CHECK_EN
   wire       err_a, err_b;
`endif

   assign a_1h = s_drv ? s_wd[31:24] : 8'bz;
   assign a_1l = s_drv ? s_wd[23:16] : 8'bz;
   assign a_2h = s_drv ? s_wd[15:8]  : 8'bz;
   assign a_2l = s_drv ? s_wd[7:0]   : 8'bz;
   assign b_1h = s_drv ? s_wd[31:24] : 8'bz;
   assign b_1l = s_drv ? s_wd[23:16] : 8'bz;
   assign b_2h = s_drv ? s_wd[15:8]  : 8'bz;
   assign b_2l = s_drv ? s_wd[7:0]   : 8'bz;

   wire [31:0] bus_a = {a_1h, a_1l, a_2h, a_2l};
   wire [31:0] bus_b = {b_1h, b_1l, b_2h, b_2l};

   ram_lane_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS_A), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ram_addr(s_addr), .ram_rw(s_rw),
      .ram_en1h(s_en[3]), .ram_en1l(s_en[2]), .ram_en2h(s_en[1]), .ram_en2l(s_en[0]),
      .ram_data1h(a_1h), .ram_data1l(a_1l), .ram_data2h(a_2h), .ram_data2l(a_2l),
      .ram_ready(rdy_a)
`ifdef RAM_BOUNDS_CHECK_EN
      , .ram_err(err_a)
`endif
   );

   ram_lane_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS_B), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ram_addr(s_addr), .ram_rw(s_rw),
      .ram_en1h(s_en[3]), .ram_en1l(s_en[2]), .ram_en2h(s_en[1]), .ram_en2l(s_en[0]),
      .ram_data1h(b_1h), .ram_data1l(b_1l), .ram_data2h(b_2h), .ram_data2l(b_2l),
      .ram_ready(rdy_b)
`ifdef RAM_BOUNDS_CHECK_EN
      , .ram_err(err_b)
`endif
   );

   typedef struct {
      int          exp_cyc;
      logic        rd;
      logic [3:0]  en;
      logic [31:0] data;
      logic        err;
   } sb_t;

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [3:0]  en;
      logic [31:0] wd;
      logic [31:0] exp;   // expected read word (both responders)
   } vec_t;

   sb_t  q_a[$];
   sb_t  q_b[$];
   vec_t tbl[16];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic bit flt(input logic [7:0] v);
      return (v === 8'hzz) || (v === 8'h00);
   endfunction

   // Enabled lanes must carry the expected bytes, and disabled lanes must float.
   function automatic bit lanes_ok(input logic [31:0] bus, input logic [3:0] en,
                                   input logic [31:0] data);
      for (int i = 0; i < 4; i++) begin
         if (en[i]) begin
            if (bus[i*8 +: 8] !== data[i*8 +: 8]) return 1'b0;
         end else if (!flt(bus[i*8 +: 8])) begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   function automatic logic is_fault(input logic [31:0] addr);
`ifdef RAM_BOUNDS_CHECK_EN
      return (addr[31:ADDR_W+2] != '0) || (addr[1:0] != 2'b00);
`else
      return (addr === 32'hxxxx_xxxx);
`endif
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int d, input int exp_cyc, input logic rw, input logic [3:0] en,
                       input logic [31:0] data, input logic [31:0] addr);
      sb_t e;
      e.exp_cyc = exp_cyc;
      e.rd      = !rw;
      e.en      = en;
      e.err     = is_fault(addr);
      e.data    = e.err ? 32'h0 : data;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic sb_check(input int d, input logic [31:0] bus, input logic err);
      sb_t e;
      bit  empty;
      empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      chk(!empty, $sformatf("unexpected_ready_dut%0d", d), 32'h1, 32'h0);
      if (!empty) begin
         if (d == 0) e = q_a.pop_front();
         else        e = q_b.pop_front();
         chk(cyc == e.exp_cyc, $sformatf("ready_cycle_dut%0d", d), cyc, e.exp_cyc);
         if (e.rd) chk(lanes_ok(bus, e.en, e.data), $sformatf("read_lanes_dut%0d", d), bus, e.data);
`ifdef RAM_BOUNDS_CHECK_EN
         chk(err == e.err, $sformatf("ram_err_dut%0d", d), err, e.err);
`else
         if (err) $display("dut%0d unexpected err input", d);
`endif
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
`ifdef RAM_BOUNDS_CHECK_EN
         if (rdy_a) sb_check(0, bus_a, err_a);
         if (rdy_b) sb_check(1, bus_b, err_b);
`else
         if (rdy_a) sb_check(0, bus_a, 1'b0);
         if (rdy_b) sb_check(1, bus_b, 1'b0);
`endif
      end
   end

   task automatic release_bus();
      s_en = '0; s_rw = 1'b0; s_drv = 1'b0; s_addr = '0; s_wd = '0;
   endtask

   task automatic present(input logic [31:0] addr, input logic rw, input logic [3:0] en,
                          input logic [31:0] wd);
      @(posedge clk); #1;
      s_addr = addr; s_rw = rw; s_en = en; s_wd = wd; s_drv = rw;
      $display("txn cyc=%0d addr=%h rw=%0d en=%b wd=%h", cyc, addr, rw, en, wd);
   endtask

   // Drop every enable for one cycle. Both responders must then release the lanes.
   task automatic gap(input string name);
      @(posedge clk); #1;
      release_bus();
      @(negedge clk);
      chk(lanes_ok(bus_a, 4'b0000, 32'h0), {name, "_float_a"}, bus_a, 32'h0);
      chk(lanes_ok(bus_b, 4'b0000, 32'h0), {name, "_float_b"}, bus_b, 32'h0);
   endtask

   task automatic run_req(input logic [31:0] addr, input logic rw, input logic [3:0] en,
                          input logic [31:0] wd, input logic [31:0] exp_a,
                          input logic [31:0] exp_b, input string name);
      int p;
      logic [31:0] ha, hb;
      present(addr, rw, en, wd);
      p = cyc;
      push(0, p + WS_A + 1, rw, en, exp_a, addr);
      push(1, p + WS_B + 1, rw, en, exp_b, addr);
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (!rw) begin
         // Both responders are in HOLD here, so the read data must still be driven.
         ha = is_fault(addr) ? 32'h0 : exp_a;
         hb = is_fault(addr) ? 32'h0 : exp_b;
         chk(lanes_ok(bus_a, en, ha), {name, "_hold_a"}, bus_a, ha);
         chk(lanes_ok(bus_b, en, hb), {name, "_hold_b"}, bus_b, hb);
      end
      gap(name);
   endtask

   initial begin
      int p;
      tbl[0]  = '{32'h0000_0010, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      tbl[1]  = '{32'h0000_0010, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
      tbl[2]  = '{32'h0000_0020, 1'b1, 4'b1111, 32'hAABB_CCDD, 32'h0};
      tbl[3]  = '{32'h0000_0020, 1'b1, 4'b0001, 32'h1122_3344, 32'h0};
      tbl[4]  = '{32'h0000_0020, 1'b0, 4'b1111, 32'h0,         32'hAABB_CC44};
      tbl[5]  = '{32'h0000_0034, 1'b1, 4'b1111, 32'h5A5A_A5A5, 32'h0};
      tbl[6]  = '{32'h0000_0030, 1'b1, 4'b1111, 32'h0BAD_F00D, 32'h0};
      tbl[7]  = '{32'h0000_0040, 1'b1, 4'b1111, 32'h4040_4040, 32'h0};
      tbl[8]  = '{32'h0000_0000, 1'b1, 4'b1111, 32'h0102_0304, 32'h0};
      tbl[9]  = '{32'h0000_0004, 1'b1, 4'b1111, 32'hA0B0_C0D0, 32'h0};
      tbl[10] = '{32'h0000_1010, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
      tbl[11] = '{32'h0000_0012, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
      tbl[12] = '{32'h0000_0020, 1'b1, 4'b1010, 32'h9988_7766, 32'h0};
      tbl[13] = '{32'h0000_0020, 1'b0, 4'b0110, 32'h0,         32'h99BB_7744};
      tbl[14] = '{32'h0000_1000, 1'b1, 4'b1111, 32'h1234_5678, 32'h0};
`ifdef RAM_BOUNDS_CHECK_EN
      tbl[15] = '{32'h0000_0000, 1'b0, 4'b1111, 32'h0,         32'h0102_0304};
`else
      tbl[15] = '{32'h0000_0000, 1'b0, 4'b1111, 32'h0,         32'h1234_5678};
`endif

      // Reset state
      @(negedge clk);
      chk(rdy_a == 1'b0, "reset_ready_a", rdy_a, 0);
      chk(rdy_b == 1'b0, "reset_ready_b", rdy_b, 0);
      chk(lanes_ok(bus_a, 4'b0000, 32'h0), "reset_float_a", bus_a, 32'h0);
      chk(lanes_ok(bus_b, 4'b0000, 32'h0), "reset_float_b", bus_b, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++)
         run_req(tbl[i].addr, tbl[i].rw, tbl[i].en, tbl[i].wd, tbl[i].exp, tbl[i].exp,
                 $sformatf("vec%0d", i));

      // Abort: the key moves from 0x30 to 0x34 while u_dut_a is in WAIT.
      // u_dut_b has already completed 0x30. It re-enters DONE from HOLD.
      present(32'h30, 1'b0, 4'b1111, 32'h0);
      p = cyc;
      push(1, p + 1, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h30);
      @(posedge clk); #1;
      s_addr = 32'h34;
      push(0, p + 3, 1'b0, 4'b1111, 32'h5A5A_A5A5, 32'h34);
      push(1, p + 3, 1'b0, 4'b1111, 32'h5A5A_A5A5, 32'h34);
      repeat (3) @(posedge clk);
      gap("abort");

      // Back-to-back reads of 0x0 and then 0x4, with no gap between them.
      // The new key is presented while u_dut_b is in HOLD.
      present(32'h0, 1'b0, 4'b1111, 32'h0);
      p = cyc;
      push(0, p + 2, 1'b0, 4'b1111, 32'h0102_0304, 32'h0);
      push(1, p + 1, 1'b0, 4'b1111, 32'h0102_0304, 32'h0);
      repeat (2) @(posedge clk); #1;
      s_addr = 32'h4;
      push(1, p + 3, 1'b0, 4'b1111, 32'hA0B0_C0D0, 32'h4);
      push(0, p + 5, 1'b0, 4'b1111, 32'hA0B0_C0D0, 32'h4);
      repeat (4) @(posedge clk);
      gap("b2b");

      // Reset lands while u_dut_a is in WAIT of a write to 0x40. u_dut_b has
      // already stored the word on entering DONE. Reset removes its ready pulse.
      present(32'h40, 1'b1, 4'b1111, 32'hFFFF_0000);
      @(posedge clk); #1;
      rst_n = 1'b0;
      release_bus();
      @(negedge clk);
      chk(rdy_a == 1'b0, "midreset_ready_a", rdy_a, 0);
      chk(rdy_b == 1'b0, "midreset_ready_b", rdy_b, 0);
      chk(lanes_ok(bus_a, 4'b0000, 32'h0), "midreset_float_a", bus_a, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_req(32'h40, 1'b0, 4'b1111, 32'h0, 32'h4040_4040, 32'hFFFF_0000, "after_reset_0x40");

      for (int i = 14; i < 16; i++)
         run_req(tbl[i].addr, tbl[i].rw, tbl[i].en, tbl[i].wd, tbl[i].exp, tbl[i].exp,
                 $sformatf("vec%0d", i));

      repeat (4) @(posedge clk);
      chk(q_a.size() == 0, "missing_ready_a", q_a.size(), 0);
      chk(q_b.size() == 0, "missing_ready_b", q_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
